sc_fallsequencer: RTL and testbench

Sequential controller that walks a falling piece down the game matrix one row per fall tick. It uses the bottom-side comparator to check for collisions: each step it presents the bitwise AND of the piece pattern and the row below. An all-zero result from the comparator means the path is free. The block sits between the matrix register bank (row read port), the bottom-side comparator, and the main game state machine (start/landing handshake).

---
 rtl/sc_fallsequencer_if.sv | 49 ++++
 rtl/sc_fallsequencer.sv | 136 +++++++++++++
 tb/tb_sc_fallsequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sc_fallsequencer_if.sv
// Bundle of the falling-piece sequencer's handshake, matrix-read and comparator signals.
// The slave modport is the sequencer; the master modport is the game/matrix side.
interface sc_fallsequencer_if #(
    parameter int FALLSEQUENCER_DATAWIDTH    = 8,
    parameter int FALLSEQUENCER_ROWADDRWIDTH = 3
);
    logic                                  SC_FALLSEQUENCER_start_In;
    logic [FALLSEQUENCER_DATAWIDTH-1:0]    SC_FALLSEQUENCER_piece_InBUS;
    logic                                  SC_FALLSEQUENCER_tick_In;
    logic                                  SC_FALLSEQUENCER_drop_In;
    logic [FALLSEQUENCER_DATAWIDTH-1:0]    SC_FALLSEQUENCER_rowbelow_InBUS;
    logic                                  SC_FALLSEQUENCER_bottomside_InLow;
    logic [FALLSEQUENCER_ROWADDRWIDTH-1:0] SC_FALLSEQUENCER_rowaddr_OutBUS;
    logic [FALLSEQUENCER_DATAWIDTH-1:0]    SC_FALLSEQUENCER_compare_OutBUS;
    logic [FALLSEQUENCER_ROWADDRWIDTH-1:0] SC_FALLSEQUENCER_row_OutBUS;
    logic                                  SC_FALLSEQUENCER_busy_Out;
    logic                                  SC_FALLSEQUENCER_land_Out;
    logic [FALLSEQUENCER_ROWADDRWIDTH-1:0] SC_FALLSEQUENCER_landrow_OutBUS;

    modport slave (
        input  SC_FALLSEQUENCER_start_In,
        input  SC_FALLSEQUENCER_piece_InBUS,
        input  SC_FALLSEQUENCER_tick_In,
        input  SC_FALLSEQUENCER_drop_In,
        input  SC_FALLSEQUENCER_rowbelow_InBUS,
        input  SC_FALLSEQUENCER_bottomside_InLow,
        output SC_FALLSEQUENCER_rowaddr_OutBUS,
        output SC_FALLSEQUENCER_compare_OutBUS,
        output SC_FALLSEQUENCER_row_OutBUS,
        output SC_FALLSEQUENCER_busy_Out,
        output SC_FALLSEQUENCER_land_Out,
        output SC_FALLSEQUENCER_landrow_OutBUS
    );

    modport master (
        output SC_FALLSEQUENCER_start_In,
        output SC_FALLSEQUENCER_piece_InBUS,
        output SC_FALLSEQUENCER_tick_In,
        output SC_FALLSEQUENCER_drop_In,
        output SC_FALLSEQUENCER_rowbelow_InBUS,
        output SC_FALLSEQUENCER_bottomside_InLow,
        input  SC_FALLSEQUENCER_rowaddr_OutBUS,
        input  SC_FALLSEQUENCER_compare_OutBUS,
        input  SC_FALLSEQUENCER_row_OutBUS,
        input  SC_FALLSEQUENCER_busy_Out,
        input  SC_FALLSEQUENCER_land_Out,
        input  SC_FALLSEQUENCER_landrow_OutBUS
    );
endinterface

// File: rtl/sc_fallsequencer.sv
// Walks a falling piece down the matrix one row per fall tick (or continuously on hard drop),
// checking the row below through the external bottom-side comparator and reporting where it lands.
module sc_fallsequencer #(
    parameter int FALLSEQUENCER_DATAWIDTH    = 8,
    parameter int FALLSEQUENCER_ROWS         = 8,
    parameter int FALLSEQUENCER_ROWADDRWIDTH = 3
) (
    input  logic              SC_FALLSEQUENCER_CLOCK_50,
    input  logic              SC_FALLSEQUENCER_RESET_InLow,
    sc_fallsequencer_if.slave seq_if
);
    localparam int DW = FALLSEQUENCER_DATAWIDTH;
    localparam int AW = FALLSEQUENCER_ROWADDRWIDTH;
    localparam logic [AW-1:0] ROW_LAST = AW'(FALLSEQUENCER_ROWS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_EVAL  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_MOVE  = 3'd4,
        ST_LAND  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] piece_q, piece_d;
    logic [DW-1:0] compare_q, compare_d;
    logic [AW-1:0] row_q, row_d;
    logic [AW-1:0] rowaddr_q, rowaddr_d;
    logic [AW-1:0] landrow_q, landrow_d;
    logic          tick_pend_q, tick_pend_d;
    logic          busy_q, busy_d;
    logic          land_q, land_d;
    logic [DW-1:0] overlap;

    // Per-column overlap between the piece and the row directly beneath it.
    generate
        for (genvar gi = 0; gi < DW; gi++) begin : g_overlap
            assign overlap[gi] = piece_q[gi] & seq_if.SC_FALLSEQUENCER_rowbelow_InBUS[gi];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        piece_d     = piece_q;
        compare_d   = compare_q;
        row_d       = row_q;
        landrow_d   = landrow_q;
        tick_pend_d = tick_pend_q;

        // A tick seen in any busy state is remembered; several coalesce into one step.
        if (state_q != ST_IDLE && seq_if.SC_FALLSEQUENCER_tick_In) begin
            tick_pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (seq_if.SC_FALLSEQUENCER_start_In) begin
                    piece_d     = seq_if.SC_FALLSEQUENCER_piece_InBUS;
                    row_d       = '0;
                    tick_pend_d = 1'b0;
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (row_q == ROW_LAST) begin
                    state_d = ST_LAND;
                end else begin
                    compare_d = overlap;
                    state_d   = ST_EVAL;
                end
            end
            ST_EVAL: begin
                state_d = seq_if.SC_FALLSEQUENCER_bottomside_InLow ? ST_WAIT : ST_LAND;
            end
            ST_WAIT: begin
                // Clearing on exit takes priority over a tick arriving in the same cycle.
                if (tick_pend_q || seq_if.SC_FALLSEQUENCER_drop_In) begin
                    tick_pend_d = 1'b0;
                    state_d     = ST_MOVE;
                end
            end
            ST_MOVE: begin
                if (row_q != ROW_LAST) begin
                    row_d = row_q + AW'(1);
                end
                state_d = ST_CHECK;
            end
            ST_LAND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered, so land/landrow are loaded on the edge that enters LAND.
        land_d = (state_d == ST_LAND) && (state_q != ST_LAND);
        if (land_d) begin
            landrow_d = row_d;
        end
        busy_d    = (state_d != ST_IDLE);
        rowaddr_d = (row_d == ROW_LAST) ? ROW_LAST : row_d + AW'(1);
    end

    always_ff @(posedge SC_FALLSEQUENCER_CLOCK_50) begin
        if (!SC_FALLSEQUENCER_RESET_InLow) begin
            state_q     <= ST_IDLE;
            piece_q     <= '0;
            compare_q   <= '0;
            row_q       <= '0;
            rowaddr_q   <= '0;
            landrow_q   <= '0;
            tick_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            land_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            piece_q     <= piece_d;
            compare_q   <= compare_d;
            row_q       <= row_d;
            rowaddr_q   <= rowaddr_d;
            landrow_q   <= landrow_d;
            tick_pend_q <= tick_pend_d;
            busy_q      <= busy_d;
            land_q      <= land_d;
        end
    end

    assign seq_if.SC_FALLSEQUENCER_rowaddr_OutBUS = rowaddr_q;
    assign seq_if.SC_FALLSEQUENCER_compare_OutBUS = compare_q;
    assign seq_if.SC_FALLSEQUENCER_row_OutBUS     = row_q;
    assign seq_if.SC_FALLSEQUENCER_busy_Out       = busy_q;
    assign seq_if.SC_FALLSEQUENCER_land_Out       = land_q;
    assign seq_if.SC_FALLSEQUENCER_landrow_OutBUS = landrow_q;
endmodule

// File: tb/tb_sc_fallsequencer.sv
// Directed bench for sc_fallsequencer: a small matrix model feeds the row port and the
// comparator is modelled as "compare word is zero"; expected values are hand-derived.
module tb_sc_fallsequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start, tick, drop;
    logic [7:0] piece;
    logic [7:0] mat [8];
    int         total = 0;
    int         bad   = 0;

    sc_fallsequencer_if #(
        .FALLSEQUENCER_DATAWIDTH(8),
        .FALLSEQUENCER_ROWADDRWIDTH(3)
    ) bus ();

    sc_fallsequencer #(
        .FALLSEQUENCER_DATAWIDTH(8),
        .FALLSEQUENCER_ROWS(8),
        .FALLSEQUENCER_ROWADDRWIDTH(3)
    ) dut (
        .SC_FALLSEQUENCER_CLOCK_50(clk),
        .SC_FALLSEQUENCER_RESET_InLow(rst_n),
        .seq_if(bus)
    );

    logic [2:0] row_o, rowaddr_o, landrow_o;
    logic [7:0] compare_o;
    logic       busy_o, land_o;

    assign bus.SC_FALLSEQUENCER_start_In          = start;
    assign bus.SC_FALLSEQUENCER_piece_InBUS       = piece;
    assign bus.SC_FALLSEQUENCER_tick_In           = tick;
    assign bus.SC_FALLSEQUENCER_drop_In           = drop;
    assign bus.SC_FALLSEQUENCER_rowbelow_InBUS    = mat[bus.SC_FALLSEQUENCER_rowaddr_OutBUS];
    assign bus.SC_FALLSEQUENCER_bottomside_InLow  = (bus.SC_FALLSEQUENCER_compare_OutBUS == 8'h00);
    assign row_o     = bus.SC_FALLSEQUENCER_row_OutBUS;
    assign rowaddr_o = bus.SC_FALLSEQUENCER_rowaddr_OutBUS;
    assign landrow_o = bus.SC_FALLSEQUENCER_landrow_OutBUS;
    assign compare_o = bus.SC_FALLSEQUENCER_compare_OutBUS;
    assign busy_o    = bus.SC_FALLSEQUENCER_busy_Out;
    assign land_o    = bus.SC_FALLSEQUENCER_land_Out;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 8; i++) mat[i] = v;
    endtask

    // Returns at the negedge where the piece sits in CHECK at row 0.
    task automatic start_piece(input logic [7:0] p);
        @(negedge clk);
        start = 1'b1;
        piece = p;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs the fall until land_Out, optionally pulsing ticks and one start while busy.
    task automatic run_to_land(input int max_cyc, input int tick_period, input int busy_start_at,
                               output int lrow, output int steps, output int bad_steps,
                               output int cmp_or, output int ra_err);
        int   cyc;
        int   prev;
        int   exp_ra;
        logic got;
        cyc = 0; prev = int'(row_o); got = 1'b0;
        steps = 0; bad_steps = 0; cmp_or = 0; ra_err = 0; lrow = -1;
        while (cyc < max_cyc && !got) begin
            @(negedge clk);
            cyc++;
            tick  = (tick_period != 0) && (cyc % tick_period == 0);
            start = (busy_start_at != 0) && (cyc == busy_start_at);
            if (start) piece = 8'h81;
            if (int'(row_o) != prev) begin
                steps++;
                if (int'(row_o) != prev + 1) bad_steps++;
                prev = int'(row_o);
            end
            cmp_or = cmp_or | int'(compare_o);
            exp_ra = (row_o == 3'd7) ? 7 : int'(row_o) + 1;
            if (busy_o && int'(rowaddr_o) != exp_ra) ra_err++;
            if (land_o) begin
                got  = 1'b1;
                lrow = int'(landrow_o);
            end
        end
        tick  = 1'b0;
        start = 1'b0;
        if (!got) check_val("land_timeout", 0, 1);
    endtask

    int lrow, steps, bsteps, cmp_or, ra_err;
    int land_at, lands;
    logic seen_land;
    logic reached;

    initial begin
        rst_n = 1'b0; start = 1'b0; tick = 1'b0; drop = 1'b0; piece = 8'h00;
        fill(8'h00);

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst_busy", int'(busy_o), 0);
        check_val("rst_land", int'(land_o), 0);
        check_val("rst_row", int'(row_o), 0);
        check_val("rst_rowaddr", int'(rowaddr_o), 0);
        check_val("rst_compare", int'(compare_o), 0);
        check_val("rst_landrow", int'(landrow_o), 0);
        rst_n = 1'b1;
        $display("txn reset checked");

        // Empty matrix, tick every 10 cycles
        fill(8'h00);
        start_piece(8'h18);
        check_val("start_busy", int'(busy_o), 1);
        run_to_land(300, 10, 0, lrow, steps, bsteps, cmp_or, ra_err);
        check_val("empty_landrow", lrow, 7);
        check_val("empty_steps", steps, 7);
        check_val("empty_bad_steps", bsteps, 0);
        check_val("empty_rowaddr", ra_err, 0);
        check_val("busy_at_land", int'(busy_o), 1);
        @(negedge clk);
        check_val("land_width", int'(land_o), 0);
        check_val("busy_after_land", int'(busy_o), 0);
        check_val("landrow_held", int'(landrow_o), 7);
        $display("txn empty_fall landrow=%0d steps=%0d", lrow, steps);

        // Collision at rowaddr 4, plus a start pulsed mid-fall that must be ignored
        fill(8'h00);
        mat[4] = 8'h08;
        start_piece(8'h18);
        run_to_land(300, 4, 6, lrow, steps, bsteps, cmp_or, ra_err);
        check_val("coll_landrow", lrow, 3);
        check_val("coll_compare", int'(compare_o), 8'h08);
        check_val("coll_steps", steps, 3);
        check_val("coll_bad_steps", bsteps, 0);
        check_val("coll_rowaddr", ra_err, 0);
        $display("txn collision landrow=%0d compare=%02h", lrow, compare_o);
        @(negedge clk);

        // Non-overlapping rows everywhere
        fill(8'h81);
        start_piece(8'h18);
        run_to_land(300, 3, 0, lrow, steps, bsteps, cmp_or, ra_err);
        check_val("nonov_compare_or", cmp_or, 0);
        check_val("nonov_landrow", lrow, 7);
        check_val("nonov_steps", steps, 7);
        $display("txn non_overlap landrow=%0d", lrow);
        @(negedge clk);

        // Tick in EVAL is remembered; three ticks in a row give one step
        fill(8'h00);
        start_piece(8'h18);          // CHECK row 0
        @(negedge clk); tick = 1'b1; // EVAL
        @(negedge clk); tick = 1'b0; // WAIT
        @(negedge clk); tick = 1'b1; // MOVE
        check_val("eval_tick_move_row", int'(row_o), 0);
        @(negedge clk);              // CHECK row 1
        check_val("eval_tick_step", int'(row_o), 1);
        @(negedge clk);              // EVAL
        @(negedge clk); tick = 1'b0; // WAIT
        @(negedge clk);              // MOVE
        @(negedge clk);              // CHECK row 2
        check_val("coalesce_step", int'(row_o), 2);
        repeat (12) @(negedge clk);
        check_val("coalesce_hold", int'(row_o), 2);
        drop = 1'b1;
        run_to_land(100, 0, 0, lrow, steps, bsteps, cmp_or, ra_err);
        drop = 1'b0;
        check_val("tick_drop_landrow", lrow, 7);
        $display("txn tick_coalesce landrow=%0d", lrow);
        @(negedge clk);

        // Hard drop from row 0 with an ignored busy start
        fill(8'h00);
        @(negedge clk);
        start = 1'b1; piece = 8'h18; drop = 1'b1;
        land_at = 0; lands = 0; lrow = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = (k == 6);
            if (k == 6) piece = 8'h81;
            if (land_o) begin
                lands++;
                if (land_at == 0) begin
                    land_at = k;
                    lrow    = int'(landrow_o);
                end
            end
        end
        drop = 1'b0; start = 1'b0;
        check_val("drop_land_cycle", land_at, 30);
        check_val("drop_landrow", lrow, 7);
        check_val("drop_land_count", lands, 1);
        $display("txn hard_drop land_cycle=%0d landrow=%0d", land_at, lrow);

        // Reset mid-fall at row 3
        fill(8'h00);
        start_piece(8'h18);
        reached = 1'b0;
        for (int k = 1; k <= 200 && !reached; k++) begin
            @(negedge clk);
            tick = (k % 2 == 0);
            if (row_o == 3'd3) reached = 1'b1;
        end
        tick = 1'b0;
        check_val("midfall_reached_row3", int'(reached), 1);
        rst_n = 1'b0;
        seen_land = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen_land = seen_land | land_o;
        end
        check_val("midrst_busy", int'(busy_o), 0);
        check_val("midrst_row", int'(row_o), 0);
        check_val("midrst_rowaddr", int'(rowaddr_o), 0);
        check_val("midrst_compare", int'(compare_o), 0);
        check_val("midrst_landrow", int'(landrow_o), 0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            seen_land = seen_land | land_o;
        end
        check_val("midrst_no_land", int'(seen_land), 0);
        check_val("midrst_idle", int'(busy_o), 0);
        $display("txn midfall_reset done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
